// File: rtl/cache_pkg.sv
// Shared types and sizes for the 2-way, 2-set write-back cache.
package cache_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int TAG_W  = 2;
  localparam int WAYS   = 2;
  localparam int SETS   = 2;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FILL,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:1];
  endfunction
endpackage

// File: rtl/cache_if.sv
// CPU-side request bus and memory-side bus of the cache.
interface cache_if;
  import cache_pkg::*;

  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data_in;
  logic [DATA_W-1:0] cpu_data_out;
  logic              cpu_ready;
  logic              hit;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    output cpu_req, cpu_write, cpu_address,
    output cpu_data_in, mem_data_in,
    input  cpu_data_out, cpu_ready, hit,
    input  mem_write, mem_address, mem_data_out
  );

  modport slave (
    input  cpu_req, cpu_write, cpu_address,
    input  cpu_data_in, mem_data_in,
    output cpu_data_out, cpu_ready, hit,
    output mem_write, mem_address, mem_data_out
  );
endinterface

// File: rtl/cache_way_array.sv
// Line storage, per-set LRU, tag lookup and victim choice.
module cache_way_array
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic              hit_way,
  output logic [DATA_W-1:0] hit_data,
  output logic              vic_way,
  output logic              vic_dirty,
  input  logic              sel_way,
  output logic [TAG_W-1:0]  sel_tag,
  output logic [DATA_W-1:0] sel_data,
  input  logic              store_en,
  input  logic [DATA_W-1:0] store_data,
  input  logic              touch_en,
  input  logic              clean_en,
  input  logic              fill_en,
  input  logic [DATA_W-1:0] fill_data
);
  line_t      lines [SETS][WAYS];
  logic [SETS-1:0] lru;
  line_t      l0, l1, vl, sl;
  logic [1:0] match;

  assign l0 = lines[idx][1'b0];
  assign l1 = lines[idx][1'b1];
  assign sl = lines[idx][sel_way];

  always_comb begin
    match[0] = l0.valid && (l0.tag == tag);
    match[1] = l1.valid && (l1.tag == tag);
    hit      = |match;
    hit_way  = ~match[0];
    hit_data = match[0] ? l0.data : l1.data;
    // An empty way always wins over the LRU way.
    if (!l0.valid)      vic_way = 1'b0;
    else if (!l1.valid) vic_way = 1'b1;
    else                vic_way = lru[idx];
    vl        = vic_way ? l1 : l0;
    vic_dirty = vl.valid && vl.dirty;
    sel_tag   = sl.tag;
    sel_data  = sl.data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          lines[s][w] <= '0;
      lru <= '0;
    end else begin
      if (store_en) begin
        lines[idx][hit_way].data  <= store_data;
        lines[idx][hit_way].dirty <= 1'b1;
      end
      if (touch_en)
        lru[idx] <= ~hit_way;
      if (clean_en)
        lines[idx][sel_way].dirty <= 1'b0;
      if (fill_en)
        lines[idx][sel_way] <= '{
          valid: 1'b1,
          dirty: 1'b0,
          tag:   tag,
          data:  fill_data
        };
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate cache FSM and memory-side driving.
module cache_controller
  import cache_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  cache_if.slave   bus
);
  state_t            state, nxt;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] data_out;
  logic              miss;
  logic              victim;

  logic              idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, hit_way;
  logic [DATA_W-1:0] hit_data;
  logic              vic_way, vic_dirty;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic              is_cmp, is_wb;

  assign idx    = req_addr[0];
  assign tag    = addr_tag(req_addr);
  assign is_cmp = (state == COMPARE);
  assign is_wb  = (state == WRITEBACK);

  cache_way_array u_ways (
    .clock      (clock),
    .reset      (reset),
    .idx        (idx),
    .tag        (tag),
    .hit        (hit),
    .hit_way    (hit_way),
    .hit_data   (hit_data),
    .vic_way    (vic_way),
    .vic_dirty  (vic_dirty),
    .sel_way    (victim),
    .sel_tag    (sel_tag),
    .sel_data   (sel_data),
    .store_en   (is_cmp && hit && req_write),
    .store_data (req_data),
    .touch_en   (is_cmp && hit),
    .clean_en   (is_wb),
    .fill_en    (state == FILL),
    .fill_data  (bus.mem_data_in)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      data_out  <= '0;
      miss      <= 1'b0;
      victim    <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (bus.cpu_req) begin
          req_write <= bus.cpu_write;
          req_addr  <= bus.cpu_address;
          req_data  <= bus.cpu_data_in;
        end
        COMPARE: if (hit) begin
          if (!req_write) data_out <= hit_data;
        end else begin
          miss   <= 1'b1;
          victim <= vic_way;
        end
        DONE: miss <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = bus.cpu_req ? COMPARE : IDLE;
      COMPARE:   nxt = hit ? DONE
                     : (vic_dirty ? WRITEBACK : ALLOCATE);
      WRITEBACK: nxt = ALLOCATE;
      ALLOCATE:  nxt = FILL;
      FILL:      nxt = COMPARE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Reset gates the strobes so an aborted request has no side effects.
  assign bus.cpu_data_out = data_out;
  assign bus.cpu_ready    = (state == DONE) && !reset;
  assign bus.hit          = (state == DONE) && !miss && !reset;
  assign bus.mem_write    = is_wb && !reset;
  assign bus.mem_address  = is_wb ? {sel_tag, idx} : req_addr;
  assign bus.mem_data_out = is_wb ? sel_data : '0;
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench: behavioural cache model vs cache_controller.
module tb_cache_controller;
  import cache_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cache_if bus ();

  cache_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // backing memory: registered read, written on mem_write
  logic [3:0] mem [8] = '{default: 4'h0};
  logic [3:0] mem_rd = 4'h0;
  always @(posedge clock) begin
    if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_out;
    mem_rd <= mem[bus.mem_address];
  end
  assign bus.mem_data_in = mem_rd;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit       is_load;
    bit [3:0] data;
    bit       hit;
    int       lat;
    int       req_cyc;
  } exp_t;

  typedef struct packed {
    bit [2:0] addr;
    bit [3:0] data;
  } wb_t;

  typedef struct {
    bit       v;
    bit       d;
    bit [1:0] tag;
    bit [3:0] data;
    int       last;
  } mline_t;

  exp_t   expq [$];
  wb_t    wbq  [$];
  mline_t mc [2][2];
  bit [3:0] arch [8];
  bit [3:0] bmem [8];
  int use_ctr = 0;

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++)
        mc[s][w] = '{v: 0, d: 0, tag: 0, data: 0, last: 0};
    for (int i = 0; i < 8; i++) arch[i] = bmem[i];
    expq.delete();
    wbq.delete();
    use_ctr = 0;
  endtask

  task automatic model_access(input bit w, input bit [2:0] a,
                              input bit [3:0] d, output exp_t e);
    bit s;
    bit [1:0] tg;
    bit [2:0] wa;
    int way;
    s = a[0];
    tg = a[2:1];
    way = -1;
    for (int i = 0; i < 2; i++)
      if (mc[s][i].v && mc[s][i].tag == tg) way = i;
    e.is_load = !w;
    e.hit = (way >= 0);
    e.lat = 2;
    e.req_cyc = 0;
    if (way < 0) begin
      if (!mc[s][0].v) way = 0;
      else if (!mc[s][1].v) way = 1;
      else way = (mc[s][0].last < mc[s][1].last) ? 0 : 1;
      e.lat = 5;
      if (mc[s][way].v && mc[s][way].d) begin
        e.lat = 6;
        wa = {mc[s][way].tag, s};
        wbq.push_back('{addr: wa, data: mc[s][way].data});
        bmem[wa] = mc[s][way].data;
      end
      mc[s][way] = '{v: 1, d: 0, tag: tg, data: bmem[a], last: 0};
    end
    if (w) begin
      mc[s][way].data = d;
      mc[s][way].d = 1;
      arch[a] = d;
    end
    e.data = arch[a];
    use_ctr++;
    mc[s][way].last = use_ctr;
  endtask

  // monitor: pops expectations whenever the DUT presents a result
  always @(negedge clock) begin
    exp_t e;
    wb_t  b;
    if (!reset) begin
      if (bus.cpu_ready) begin
        if (expq.size() == 0) chk("spurious_ready", 1, 0);
        else begin
          e = expq.pop_front();
          chk("hit", bus.hit, e.hit);
          chk("latency", cyc - e.req_cyc + 1, e.lat);
          if (e.is_load) chk("load_data", bus.cpu_data_out, e.data);
        end
      end
      if (bus.mem_write) begin
        if (wbq.size() == 0) chk("spurious_mem_write", 1, 0);
        else begin
          b = wbq.pop_front();
          chk("wb_addr", bus.mem_address, b.addr);
          chk("wb_data", bus.mem_data_out, b.data);
        end
      end
    end
  end

  task automatic run(input bit w, input bit [2:0] a,
                     input bit [3:0] d, input bit hold);
    exp_t e;
    bit got;
    model_access(w, a, d, e);
    @(negedge clock);
    bus.cpu_req = 1'b1;
    bus.cpu_write = w;
    bus.cpu_address = a;
    bus.cpu_data_in = d;
    @(posedge clock);
    #1;
    e.req_cyc = cyc;
    expq.push_back(e);
    if (!hold) bus.cpu_req = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if (bus.cpu_ready) got = 1;
      else if (hold) begin
        bus.cpu_write = 1'($urandom_range(1));
        bus.cpu_address = 3'($urandom_range(7));
        bus.cpu_data_in = 4'($urandom_range(15));
      end
    end
    if (!got) chk("ready_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    exp_t dummy;
    int readies;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int readies;
    bus.cpu_req = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data_in = '0;
    for (int i = 0; i < 8; i++) bmem[i] = 4'h0;

    do_reset();
    #1;
    chk("rst_data_out", bus.cpu_data_out, 0);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_data_out", bus.mem_data_out, 0);

    // reset hits the dirty eviction mid-writeback
    run(1, 3'd1, 4'hA, 0);
    run(1, 3'd3, 4'hB, 0);
    model_access(0, 3'd5, 4'h0, e);
    @(negedge clock);
    bus.cpu_req = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_address = 3'd5;
    @(posedge clock);
    #1;
    bus.cpu_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("wb_under_reset", bus.mem_write, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    readies = 0;
    repeat (10) begin
      @(negedge clock);
      #1;
      if (bus.cpu_ready) readies++;
    end
    chk("abandoned_ready", readies, 0);
    chk("mem1_after_abort", mem[1], 0);
    run(0, 3'd3, 4'h0, 0);

    // cold miss then hit
    do_reset();
    run(0, 3'd5, 4'h0, 0);
    run(0, 3'd5, 4'h0, 0);

    // store then load, no eviction traffic
    do_reset();
    run(1, 3'd1, 4'hA, 0);
    run(0, 3'd1, 4'h0, 0);

    // dirty eviction of address 1
    do_reset();
    run(1, 3'd1, 4'hA, 0);
    run(1, 3'd3, 4'hB, 0);
    run(0, 3'd5, 4'h0, 0);
    chk("mem1_after_wb", mem[1], 4'hA);

    // LRU picks address 3
    do_reset();
    run(0, 3'd1, 4'h0, 0);
    run(0, 3'd3, 4'h0, 0);
    run(0, 3'd1, 4'h0, 0);
    run(0, 3'd5, 4'h0, 0);
    run(0, 3'd1, 4'h0, 0);

    // requests held high with junk through misses
    run(0, 3'd7, 4'h0, 1);
    run(1, 3'd2, 4'h6, 1);
    run(0, 3'd2, 4'h0, 1);

    for (int n = 0; n < 200; n++)
      run(1'($urandom_range(1)), 3'($urandom_range(7)),
          4'($urandom_range(15)), 1'($urandom_range(1)));
    bus.cpu_req = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("expq_drained", expq.size(), 0);
    chk("wbq_drained", wbq.size(), 0);
    for (int i = 0; i < 8; i++)
      chk("backing_mem", mem[i], bmem[i]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameters: none; address width is fixed at 3 bits and data width at 4 bits, matching the backing memory.
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  request strobe; sampled only in IDLE.
REQ-005 cpu_write  input  1  1=store, 0=load; sampled with cpu_req.
REQ-006 cpu_address  input  3  byte address; index=cpu_address[0], tag=cpu_address[2:1].
REQ-007 cpu_data_in  input  4  store data; sampled with cpu_req.
REQ-008 cpu_data_out  output  4  load result; valid while cpu_ready=1 and held until the next completion.
REQ-009 cpu_ready  output  1  one-cycle completion pulse.
REQ-010 hit  output  1  valid with cpu_ready: 1 if the first lookup hit, 0 if a miss was serviced.
REQ-011 mem_write  output  1  write enable to backing memory.
REQ-012 mem_address  output  3  address to backing memory.
REQ-013 mem_data_out  output  4  write data to backing memory.
REQ-014 mem_data_in  input  4  backing memory read data; valid the cycle after mem_address was presented.

Function
REQ-015 The cache SHALL be 2-way set-associative with 2 sets; each way holds valid, dirty, tag[1:0] and data[3:0]; each set holds one LRU bit naming its least-recently-used way.
REQ-016 The FSM SHALL have states IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL and DONE.
REQ-017 IDLE: on cpu_req=1, the block SHALL latch write, address and data and go to COMPARE; otherwise it SHALL stay in IDLE.
REQ-018 cpu_req SHALL be ignored in every state other than IDLE.
REQ-019 COMPARE: a hit (valid and tag match in either way) SHALL cause a load to latch the line data into cpu_data_out, or a store to write the data and set dirty=1; the set LRU SHALL become the other way; next state DONE.
REQ-020 COMPARE miss: the victim SHALL be the first invalid way (way0 before way1), otherwise the LRU way; a valid dirty victim SHALL go to WRITEBACK, any other victim to ALLOCATE; a miss flag SHALL be recorded.
REQ-021 WRITEBACK (1 cycle): the block SHALL drive mem_write=1, mem_address={victim tag, index} and mem_data_out=victim data, clear the victim dirty bit and go to ALLOCATE.
REQ-022 ALLOCATE (1 cycle): the block SHALL drive mem_write=0 and mem_address=the latched request address, then go to FILL.
REQ-023 FILL (1 cycle): the victim SHALL be loaded with valid=1, dirty=0, the request tag and data from mem_data_in; next state COMPARE, where the re-lookup SHALL hit.
REQ-024 DONE (1 cycle): the block SHALL assert cpu_ready=1 and hit=~miss flag, clear the miss flag and go to IDLE.
REQ-025 Latency from the request-sampling edge to cpu_ready: 2 cycles on a hit, 5 on a clean miss, 6 on a dirty miss.
REQ-026 Outside WRITEBACK, mem_write SHALL be 0; outside WRITEBACK and ALLOCATE, mem_address SHALL equal the latched request address and mem_data_out SHALL be 0.
REQ-027 A store miss SHALL allocate the line and then complete as a store hit, leaving the line dirty; backing memory is not written until eviction (write-back, write-allocate).

Reset
REQ-028 While reset=1 at a posedge, the block SHALL enter IDLE and clear all valid, dirty, tag, data and LRU bits, the miss flag and all latched request fields.
REQ-029 After reset, cpu_data_out=0, cpu_ready=0, hit=0, mem_write=0, mem_address=0 and mem_data_out=0.
REQ-030 mem_write SHALL be forced to 0 combinationally while reset=1, so that reset asserted during WRITEBACK never writes memory; an in-flight request SHALL be abandoned without a cpu_ready pulse.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state enum, ADDR_W=3, DATA_W=4, TAG_W=2, WAYS=2, SETS=2 and the line struct.
REQ-032 One sub-module, cache_way_array, SHALL hold line storage, the LRU bits, hit/way detection and victim selection; the FSM and memory-side driving stay in cache_controller.

Verification
REQ-033 Reset, then load from 3'b101 -> mem_address=5 in ALLOCATE, cpu_ready 5 cycles after the request, data 0, hit=0; repeat the load -> cpu_ready after 2 cycles, hit=1.
REQ-034 Store 4'hA to address 1, then load address 1 -> 4'hA with hit=1; mem_write is never asserted.
REQ-035 Store 4'hA@1, store 4'hB@3, then load address 5 (all set 1) -> one WRITEBACK cycle with mem_write=1, mem_address=1, mem_data_out=4'hA; cpu_ready after 6 cycles; memory[1]=4'hA afterwards.
REQ-036 Run the REQ-035 sequence with reset asserted during the WRITEBACK cycle -> mem_write=0 and no cpu_ready pulse; memory[1] stays 0; a following load of address 3 misses (hit=0).
REQ-037 Hold cpu_req=1 with changing address during a miss -> only the IDLE-sampled request is serviced; the next request is taken on the cycle after DONE.
REQ-038 Load 1, load 3, load 1, then load 5 -> address 3's way (LRU) is evicted; a later load of 1 reports hit=1.
